// File: rtl/max_pool_sched_if.sv
// Signal bundle for max_pool_sched: job control, input line stream, pool-unit link, output line stream.
// master = the sequencer, slave = the host / stream side around it.
interface max_pool_sched_if #(
   parameter int LEN_W = 16
) ();
   logic             start;
   logic [LEN_W-1:0] num_lines;
   logic             busy;
   logic             done;

   logic [511:0]     in_data;
   logic             in_valid;
   logic             in_ready;

   logic [127:0]     pool_in;
   logic [31:0]      pool_out;

   logic [511:0]     out_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_last;

   logic [31:0]      perf_stall;

   modport master (
      input  start, num_lines, in_data, in_valid, pool_out, out_ready,
      output busy, done, in_ready, pool_in, out_data, out_valid, out_last, perf_stall
   );

   modport slave (
      output start, num_lines, in_data, in_valid, pool_out, out_ready,
      input  busy, done, in_ready, pool_in, out_data, out_valid, out_last, perf_stall
   );
endinterface

// File: rtl/max_pool_sched.sv
// Time-shares one external 4-to-1 signed max-pool unit over 512-bit lines, packing 16 results per output line.
// Define POOL_PERF_CNT_EN to build the saturating output-backpressure counter on perf_stall.
module max_pool_sched #(
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   max_pool_sched_if.master bus,
   output logic [1:0]       dbg_state_o
);

   // Streams transfer on a rising edge where valid and ready are both high; a producer
   // holding valid keeps its data (and out_last) stable until that edge.

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_POOL = 2'd2,
      S_EMIT = 2'd3
   } state_e;

   state_e           state_q;
   logic [LEN_W-1:0] remaining_q;
   logic [1:0]       k_q;
   logic [1:0]       g_q;
   logic [511:0]     line_q;
   logic [511:0]     acc_q;
   logic             busy_q;
   logic             done_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             out_last_q;

   logic             start_acc;
   logic             in_hs;
   logic             out_hs;
   logic [3:0]       slot;
   logic             last_window;
   logic             group_full;
   logic             job_drained;

   assign start_acc   = (state_q == S_IDLE) && bus.start;
   assign in_hs       = in_ready_q && bus.in_valid;
   assign out_hs      = out_valid_q && bus.out_ready;
   assign slot        = {k_q, g_q};
   assign last_window = (g_q == 2'd3);
   assign group_full  = (k_q == 2'd3);
   assign job_drained = (remaining_q == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         k_q         <= 2'd0;
         g_q         <= 2'd0;
         line_q      <= '0;
         acc_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_acc) begin
                  remaining_q <= bus.num_lines;
                  k_q         <= 2'd0;
                  acc_q       <= '0;
                  if (bus.num_lines == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     state_q    <= S_LOAD;
                     busy_q     <= 1'b1;
                     in_ready_q <= 1'b1;
                  end
               end
            end

            S_LOAD: begin
               if (in_hs) begin
                  line_q      <= bus.in_data;
                  remaining_q <= remaining_q - LEN_W'(1);
                  g_q         <= 2'd0;
                  in_ready_q  <= 1'b0;
                  state_q     <= S_POOL;
               end
            end

            // One window per cycle; the pool unit answers combinationally from pool_in.
            S_POOL: begin
               acc_q[{slot, 5'b0} +: 32] <= bus.pool_out;
               g_q                       <= g_q + 2'd1;
               if (last_window) begin
                  if (group_full || job_drained) begin
                     state_q     <= S_EMIT;
                     out_valid_q <= 1'b1;
                     out_last_q  <= job_drained;
                  end else begin
                     k_q        <= k_q + 2'd1;
                     state_q    <= S_LOAD;
                     in_ready_q <= 1'b1;
                  end
               end
            end

            S_EMIT: begin
               if (out_hs) begin
                  acc_q       <= '0;
                  k_q         <= 2'd0;
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  if (job_drained) begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q    <= S_LOAD;
                     in_ready_q <= 1'b1;
                  end
               end
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.in_ready  = in_ready_q;
   assign bus.pool_in   = line_q[{g_q, 7'b0} +: 128];
   assign bus.out_data  = acc_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_last  = out_last_q;
   assign dbg_state_o   = state_q;

`ifdef POOL_PERF_CNT_EN
   logic [31:0] perf_q;
   logic [31:0] perf_d;

   always_comb begin
      perf_d = perf_q;
      if (start_acc) begin
         perf_d = '0;
      end else if (out_valid_q && !bus.out_ready && (perf_q != 32'hFFFF_FFFF)) begin
         perf_d = perf_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_q <= '0;
      end else begin
         perf_q <= perf_d;
      end
   end

   assign bus.perf_stall = perf_q;
`else
   assign bus.perf_stall = 32'd0;
`endif

endmodule

// File: tb/tb_max_pool_sched.sv
// Self-checking bench for max_pool_sched: random lines and handshakes checked against a line-level model.
module tb_max_pool_sched;
   localparam int LEN_W = 16;

`ifdef POOL_PERF_CNT_EN
   localparam logic [31:0] EXP_STALL = 32'd10;
`else
   localparam logic [31:0] EXP_STALL = 32'd0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [1:0]   dbg_state;
   int           n_pass = 0;
   int           n_total = 0;
   logic [511:0] lines_q[$];
   logic [511:0] got_q[$];

   max_pool_sched_if #(.LEN_W(LEN_W)) bus ();

   max_pool_sched #(.LEN_W(LEN_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] max4(input logic [127:0] w);
      logic signed [31:0] m;
      logic signed [31:0] c;
      m = w[31:0];
      for (int j = 1; j < 4; j++) begin
         c = w[32*j +: 32];
         if (c > m) m = c;
      end
      return m;
   endfunction

   // External pool unit stand-in.
   always_comb bus.pool_out = max4(bus.pool_in);

   task automatic make_ascending(input int n);
      logic [511:0] l;
      lines_q.delete();
      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < 16; j++) l[32*j +: 32] = 32'(16*i + j);
         lines_q.push_back(l);
      end
   endtask

   task automatic make_random(input int n);
      logic [511:0] l;
      lines_q.delete();
      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < 16; j++) l[32*j +: 32] = $urandom;
         lines_q.push_back(l);
      end
   endtask

   task automatic check_reset_values(input string tag);
      n_total++;
      if (bus.in_ready !== 1'b0) $display("FAIL %s in_ready: got %b want 0", tag, bus.in_ready); else n_pass++;
      n_total++;
      if (bus.out_valid !== 1'b0) $display("FAIL %s out_valid: got %b want 0", tag, bus.out_valid); else n_pass++;
      n_total++;
      if (bus.out_data !== '0) $display("FAIL %s out_data: got %h want 0", tag, bus.out_data); else n_pass++;
      n_total++;
      if (bus.out_last !== 1'b0) $display("FAIL %s out_last: got %b want 0", tag, bus.out_last); else n_pass++;
      n_total++;
      if (bus.busy !== 1'b0) $display("FAIL %s busy: got %b want 0", tag, bus.busy); else n_pass++;
      n_total++;
      if (bus.done !== 1'b0) $display("FAIL %s done: got %b want 0", tag, bus.done); else n_pass++;
      n_total++;
      if (bus.perf_stall !== 32'd0) $display("FAIL %s perf_stall: got %0d want 0", tag, bus.perf_stall); else n_pass++;
      n_total++;
      if (bus.pool_in !== '0) $display("FAIL %s pool_in: got %h want 0", tag, bus.pool_in); else n_pass++;
      n_total++;
      if (dbg_state !== 2'd0) $display("FAIL %s dbg_state: got %0d want 0 (idle)", tag, dbg_state); else n_pass++;
   endtask

   // Driver + scoreboard for one job over lines_q.
   // rmode: 0 out_ready high, 1 random out_ready, 2 out_ready low for the first 10 cycles of each output line.
   task automatic run_job(input int n, input int rmode, input bit rand_in, output int stalls);
      logic [511:0] exp_q[$];
      bit           exp_last_q[$];
      logic [511:0] acc;
      logic [511:0] held;
      bit           held_last, holding, fin, acc_now, hs_now, quiet;
      int           idx, cyc, since, emit_cyc;
      acc = '0; held = '0; held_last = 1'b0; holding = 1'b0; fin = 1'b0; quiet = 1'b1;
      idx = 0; cyc = 0; since = -1; emit_cyc = 0; stalls = 0;

      for (int i = 0; i < n; i++) begin
         for (int g = 0; g < 4; g++) acc[32*(4*(i%4)+g) +: 32] = max4(lines_q[i][128*g +: 128]);
         if ((i % 4 == 3) || (i == n - 1)) begin
            exp_q.push_back(acc);
            exp_last_q.push_back(i == n - 1);
            acc = '0;
         end
      end
      got_q.delete();

      bus.start     = 1'b1;
      bus.num_lines = LEN_W'(n);
      @(posedge clk); #1;
      bus.start = 1'b0;
      n_total++;
      if (bus.busy !== 1'b1) $display("FAIL busy_after_start: got %b want 1", bus.busy); else n_pass++;
      n_total++;
      if (bus.perf_stall !== 32'd0) $display("FAIL perf_clear_on_start: got %0d want 0", bus.perf_stall); else n_pass++;

      while (!fin && cyc < 40*n + 100) begin
         bus.in_valid = (idx < n) && (rand_in ? ($urandom_range(0, 1) == 1) : 1'b1);
         bus.in_data  = (idx < n) ? lines_q[idx] : '0;
         // Starts while busy must be ignored; a re-latched count would change the output stream.
         bus.start     = rand_in ? ($urandom_range(0, 3) == 0) : 1'b0;
         bus.num_lines = LEN_W'($urandom_range(1, 20));
         case (rmode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ($urandom_range(0, 2) != 0);
            default: bus.out_ready = (emit_cyc >= 10);
         endcase
         acc_now = bus.in_ready && bus.in_valid;
         hs_now  = bus.out_valid && bus.out_ready;

         if (since >= 1 && since <= 4 && (bus.in_ready || bus.out_valid)) quiet = 1'b0;
         if (since == 5) begin
            n_total++;
            if (!quiet || !(bus.in_ready || bus.out_valid))
               $display("FAIL pool_latency: in_ready=%b out_valid=%b quiet=%b, want 4 idle cycles then ready/valid",
                        bus.in_ready, bus.out_valid, quiet);
            else n_pass++;
            since = -1;
            quiet = 1'b1;
         end

         if (bus.out_valid) begin
            n_total++;
            if (bus.in_ready !== 1'b0) $display("FAIL in_ready_in_emit: got %b want 0", bus.in_ready); else n_pass++;
            if (holding) begin
               n_total++;
               if (bus.out_data !== held || bus.out_last !== held_last)
                  $display("FAIL out_hold: got %h/%b want %h/%b", bus.out_data, bus.out_last, held, held_last);
               else n_pass++;
            end
         end

         if (hs_now) begin
            got_q.push_back(bus.out_data);
            n_total++;
            if (exp_q.size() == 0) begin
               $display("FAIL unexpected_output: got %h want no line", bus.out_data);
            end else begin
               if (bus.out_data !== exp_q[0] || bus.out_last !== exp_last_q[0])
                  $display("FAIL out_line: got %h last=%b want %h last=%b", bus.out_data, bus.out_last, exp_q[0], exp_last_q[0]);
               else n_pass++;
               exp_q.delete(0);
               exp_last_q.delete(0);
            end
            holding  = 1'b0;
            emit_cyc = 0;
         end else if (bus.out_valid) begin
            holding   = 1'b1;
            held      = bus.out_data;
            held_last = bus.out_last;
            stalls++;
            emit_cyc++;
         end

         @(posedge clk); #1;
         cyc++;
         if (acc_now) begin
            idx++;
            since = 1;
         end else if (since >= 1) begin
            since++;
         end

         if (hs_now && exp_q.size() == 0) begin
            fin = 1'b1;
            bus.start = 1'b0;
            n_total++;
            if (bus.done !== 1'b1) $display("FAIL done_after_last: got %b want 1", bus.done); else n_pass++;
            n_total++;
            if (bus.busy !== 1'b0) $display("FAIL busy_after_last: got %b want 0", bus.busy); else n_pass++;
         end
      end
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      if (!fin) begin
         n_total++;
         $display("FAIL job_timeout: got %0d lines still pending want 0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset");
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int stalls, bad;
      make_ascending(4);
      run_job(4, 0, 1'b0, stalls);
      n_total++;
      if (got_q.size() != 1) begin
         $display("FAIL basic_count: got %0d lines want 1", got_q.size());
      end else begin
         bad = 0;
         for (int k = 0; k < 4; k++)
            for (int g = 0; g < 4; g++)
               if (got_q[0][32*(4*k+g) +: 32] !== 32'(16*k + 4*g + 3)) bad++;
         if (bad != 0) $display("FAIL basic_words: got %0d wrong words want 0", bad); else n_pass++;
      end
   endtask

   task automatic test_negative();
      int stalls;
      logic [511:0] l;
      logic [511:0] want;
      l = '0;
      l[31:0]  = 32'hFFFF_FFFB;
      l[63:32] = 32'hFFFF_FFFF;
      l[95:64] = 32'hFFFF_FFF9;
      l[127:96] = 32'hFFFF_FFFD;
      lines_q.delete();
      lines_q.push_back(l);
      want = '0;
      want[31:0] = 32'hFFFF_FFFF;
      run_job(1, 0, 1'b0, stalls);
      n_total++;
      if (got_q.size() != 1 || got_q[0] !== want)
         $display("FAIL negative_line: got %0d lines, first %h want %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, want);
      else n_pass++;
   endtask

   task automatic test_six();
      int stalls;
      make_ascending(6);
      run_job(6, 0, 1'b0, stalls);
      n_total++;
      if (got_q.size() != 2 || got_q[1][511:256] !== '0 || got_q[1][255:0] === '0)
         $display("FAIL six_lines: got %0d lines want 2 with upper half of second zero", got_q.size());
      else n_pass++;
   endtask

   task automatic test_stall();
      int stalls;
      make_random(4);
      run_job(4, 2, 1'b0, stalls);
      n_total++;
      if (bus.perf_stall !== EXP_STALL) $display("FAIL perf_stall: got %0d want %0d", bus.perf_stall, EXP_STALL); else n_pass++;
   endtask

   task automatic test_zero();
      bit bad;
      bus.start     = 1'b1;
      bus.num_lines = '0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n_total++;
      if (bus.done !== 1'b1) $display("FAIL zero_done: got %b want 1", bus.done); else n_pass++;
      bad = (bus.busy || bus.out_valid || bus.in_ready);
      @(posedge clk); #1;
      n_total++;
      if (bus.done !== 1'b0) $display("FAIL zero_done_pulse: got %b want 0", bus.done); else n_pass++;
      for (int i = 0; i < 5; i++) begin
         if (bus.busy || bus.out_valid || bus.in_ready) bad = 1'b1;
         @(posedge clk); #1;
      end
      n_total++;
      if (bad) $display("FAIL zero_quiet: got busy/out_valid/in_ready asserted want none"); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int stalls;
      make_ascending(3);
      run_job(3, 0, 1'b0, stalls);
      make_random(5);
      run_job(5, 1, 1'b1, stalls);
   endtask

   task automatic test_random();
      int stalls, n;
      for (int t = 0; t < 4; t++) begin
         n = $urandom_range(1, 9);
         make_random(n);
         run_job(n, 1, 1'b1, stalls);
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid_job();
      int  acc_cnt, cyc, stalls;
      bit  hs;
      acc_cnt = 0;
      cyc     = 0;
      make_ascending(4);
      bus.start     = 1'b1;
      bus.num_lines = LEN_W'(4);
      @(posedge clk); #1;
      bus.start = 1'b0;
      while (acc_cnt < 2 && cyc < 100) begin
         bus.in_valid = 1'b1;
         bus.in_data  = lines_q[acc_cnt];
         hs = bus.in_ready;
         @(posedge clk); #1;
         cyc++;
         if (hs) acc_cnt++;
      end
      bus.in_valid = 1'b0;
      if (acc_cnt < 2) begin
         n_total++;
         $display("FAIL reset_mid_timeout: got %0d lines accepted want 2", acc_cnt);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check_reset_values("reset_mid");
      rst_n = 1'b1;
      make_random(4);
      run_job(4, 0, 1'b0, stalls);
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.num_lines = '0;
      bus.in_data   = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      test_reset();
      test_basic();
      test_negative();
      test_six();
      test_stall();
      test_zero();
      test_back_to_back();
      test_random();
      test_reset_mid_job();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
